// File: rtl/specmd_pipe.sv
// specmd_pipe: pipelined special-operand resolver for the FPU mul/div path.
// Classifies the operand pair (zero/inf/NaN flags), picks the NaN payload,
// and carries the result through STAGES elastic valid/ready register slots.
// Sticky INV/DBZ flags accumulate on each output handshake.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   input handshake
//   fdiv                  1 = divide, 0 = multiply
//   fla, flb              operand class {zero, inf, sNaN, NaN}
//   fra, frb              operand fractions (FRAC_W)
//   in_tag                sideband tag (TAG_W)
//   out_valid / out_ready output handshake
//   flq                   {nan[FRAC_W:0], ZEROq, INFq, NANq, INV, DBZ}
//   out_tag               tag matching flq
//   sticky_clr            clear sticky flags
//   sticky_flags          {DBZ seen, INV seen}
module specmd_pipe #(
  parameter int unsigned FRAC_W = 52,
  parameter int unsigned STAGES = 1,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              fdiv,
  input  logic [3:0]        fla,
  input  logic [3:0]        flb,
  input  logic [FRAC_W-1:0] fra,
  input  logic [FRAC_W-1:0] frb,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W+5:0] flq,
  output logic [TAG_W-1:0]  out_tag,
  input  logic              sticky_clr,
  output logic [1:0]        sticky_flags
);

  localparam int unsigned NAN_W   = FRAC_W + 1;
  localparam int unsigned FLQ_W   = FRAC_W + 6;
  localparam int unsigned PL_W    = FLQ_W + TAG_W;
  localparam int unsigned DBZ_BIT = TAG_W;
  localparam int unsigned INV_BIT = TAG_W + 1;

  // Reject unsupported pipeline depths at elaboration.
  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $fatal(1, "specmd_pipe: STAGES must be in 1..4");
    end
  endgenerate

  logic             a_nan;
  logic             b_nan;
  logic             dbz;
  logic             inv;
  logic             nanq;
  logic             infq;
  logic             zeroq;
  logic [NAN_W-1:0] nan;
  logic [PL_W-1:0]  in_pl;

  // Operand classification and NaN payload selection (ahead of stage 0).
  always_comb begin
    a_nan = fla[0] | fla[1];
    b_nan = flb[0] | flb[1];
    dbz   = fdiv & flb[3] & (fla == 4'd0);
    inv   = fla[1] | flb[1]
          | (fdiv ? ((fla[3] & flb[3]) | (fla[2] & flb[2]))
                  : ((fla[3] & flb[2]) | (fla[2] & flb[3])));
    nanq  = inv | fla[0] | flb[0];
    if (fdiv) begin
      infq  = (fla[2] & ~nanq) | dbz;
      zeroq = (fla[3] | flb[2]) & ~nanq;
    end else begin
      infq  = (fla[2] | flb[2]) & ~nanq;
      zeroq = (fla[3] | flb[3]) & ~nanq;
    end
    // Quiet bit forced to 1 whichever source supplies the payload.
    if (a_nan) begin
      nan = {2'b11, fra[FRAC_W-2:0]};
    end else if (b_nan) begin
      nan = {2'b11, frb[FRAC_W-2:0]};
    end else begin
      nan = {2'b11, (FRAC_W-1)'(0)};
    end
    in_pl = {nan, zeroq, infq, nanq, inv, dbz, in_tag};
  end

  // Fraction MSBs are replaced by the forced quiet bit.
  logic unused_frac_msb;
  assign unused_frac_msb = fra[FRAC_W-1] ^ frb[FRAC_W-1];

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] adv;
  logic [PL_W-1:0]   pl_q [STAGES];
  logic [PL_W-1:0]   pl_d [STAGES];
  logic              in_rdy;
  logic              out_hs;
  logic [1:0]        sticky_q;
  logic [1:0]        sticky_d;

  // Elastic slot control: a slot may move on when the slot after it is empty
  // or moving; payloads load only when valid data actually arrives.
  always_comb begin
    adv             = '0;
    adv[STAGES-1]   = out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      adv[k] = ~valid_q[k+1] | adv[k+1];
    end
    in_rdy  = ~valid_q[0] | adv[0];
    valid_d = valid_q;
    for (int k = 0; k < int'(STAGES); k++) begin
      pl_d[k] = pl_q[k];
    end
    if (in_rdy) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        pl_d[0] = in_pl;
      end
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      if (~valid_q[k] | adv[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          pl_d[k] = pl_q[k-1];
        end
      end
    end
  end

  // Sticky flags: a handshake flag beats a same-cycle clear.
  always_comb begin
    out_hs   = valid_q[STAGES-1] & out_ready;
    sticky_d = sticky_clr ? 2'b00 : sticky_q;
    if (out_hs) begin
      sticky_d = sticky_d | {pl_q[STAGES-1][DBZ_BIT], pl_q[STAGES-1][INV_BIT]};
    end
  end

  // Slot, payload and sticky registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      sticky_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        pl_q[k] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      sticky_q <= sticky_d;
      for (int k = 0; k < int'(STAGES); k++) begin
        pl_q[k] <= pl_d[k];
      end
    end
  end

  assign in_ready     = in_rdy;
  assign out_valid    = valid_q[STAGES-1];
  assign flq          = pl_q[STAGES-1][PL_W-1:TAG_W];
  assign out_tag      = pl_q[STAGES-1][TAG_W-1:0];
  assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_specmd_pipe.sv
module tb_specmd_pipe;

  localparam int unsigned FRAC_W = 52;
  localparam int unsigned STAGES = 2;
  localparam int unsigned TAG_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              fdiv;
  logic [3:0]        fla;
  logic [3:0]        flb;
  logic [FRAC_W-1:0] fra;
  logic [FRAC_W-1:0] frb;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [57:0]       flq;
  logic [TAG_W-1:0]  out_tag;
  logic              sticky_clr;
  logic [1:0]        sticky_flags;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [57:0] flq;
    logic [3:0]  tag;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] sticky_m;
  logic [57:0] held;

  specmd_pipe #(.FRAC_W(FRAC_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .fdiv(fdiv), .fla(fla), .flb(flb), .fra(fra), .frb(frb), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .flq(flq), .out_tag(out_tag),
    .sticky_clr(sticky_clr), .sticky_flags(sticky_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // IEEE-style reference: classify each operand, then apply mul/div rules.
  function automatic logic [57:0] model(input logic d, input logic [3:0] fa, input logic [3:0] fb,
                                        input logic [51:0] ra, input logic [51:0] rb);
    logic a_zero, a_inf, a_snan, a_anynan, a_fin;
    logic b_zero, b_inf, b_snan, b_anynan;
    logic inv_m, dbz_m, nanq_m, inf_m, zero_m;
    logic [51:0] src;
    a_zero = fa[3]; a_inf = fa[2]; a_snan = fa[1]; a_anynan = fa[0] | fa[1]; a_fin = (fa == 4'd0);
    b_zero = fb[3]; b_inf = fb[2]; b_snan = fb[1]; b_anynan = fb[0] | fb[1];
    if (!d) inv_m = a_snan || b_snan || (a_zero && b_inf) || (a_inf && b_zero);
    else    inv_m = a_snan || b_snan || (a_zero && b_zero) || (a_inf && b_inf);
    dbz_m  = d && a_fin && b_zero;
    nanq_m = inv_m || fa[0] || fb[0];
    inf_m  = 1'b0;
    zero_m = 1'b0;
    if (!nanq_m) begin
      if (!d) begin
        inf_m  = a_inf || b_inf;
        zero_m = a_zero || b_zero;
      end else begin
        inf_m  = a_inf;
        zero_m = a_zero || b_inf;
      end
    end
    if (dbz_m) inf_m = 1'b1;
    if (a_anynan)      src = ra;
    else if (b_anynan) src = rb;
    else               src = 52'd0;
    return {2'b11, src[50:0], zero_m, inf_m, nanq_m, inv_m, dbz_m};
  endfunction

  function automatic logic [3:0] pick_class();
    logic [3:0] t [6];
    t = '{4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b0001, 4'b0011};
    return t[$urandom_range(0, 5)];
  endfunction

  // One isolated operation with out_ready=1; checks latency, result and tag.
  task automatic dir_op(input string name, input logic d, input logic [3:0] fa, input logic [3:0] fb,
                        input logic [51:0] ra, input logic [51:0] rb, input logic [3:0] tg,
                        input logic [57:0] exp_flq, input logic clr_at_out);
    fdiv = d; fla = fa; flb = fb; fra = ra; frb = rb; in_tag = tg;
    in_valid = 1'b1; out_ready = 1'b1; sticky_clr = 1'b0;
    #1 chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({name, "_lat1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    sticky_clr = clr_at_out;
    #1;
    chk({name, "_ov"}, 64'(out_valid), 64'd1);
    chk({name, "_flq"}, 64'(flq), 64'(exp_flq));
    chk({name, "_flq_model"}, 64'(flq), 64'(model(d, fa, fb, ra, rb)));
    chk({name, "_tag"}, 64'(out_tag), 64'(tg));
    @(negedge clk);
    sticky_clr = 1'b0;
    #1 chk({name, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  // One randomized (or draining) cycle against the scoreboard.
  task automatic step(input logic rnd);
    exp_t e;
    exp_t n;
    logic hs;
    hs = 1'b0;
    e  = '0;
    @(negedge clk);
    chk("rnd_sticky", 64'(sticky_flags), 64'(sticky_m));
    if (rnd) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      sticky_clr = ($urandom_range(0, 7) == 0);
      fdiv       = 1'($urandom_range(0, 1));
      fla        = pick_class();
      flb        = pick_class();
      fra        = 52'({$urandom(), $urandom()});
      frb        = 52'({$urandom(), $urandom()});
      in_tag     = 4'($urandom());
    end else begin
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      sticky_clr = 1'b0;
    end
    #1;
    chk("rnd_in_ready", 64'(in_ready), 64'((sb.size() < int'(STAGES)) || out_ready));
    if (sb.size() == 0) begin
      chk("rnd_ov_empty", 64'(out_valid), 64'd0);
    end else if (out_valid) begin
      chk("rnd_flq", 64'(flq), 64'(sb[0].flq));
      chk("rnd_tag", 64'(out_tag), 64'(sb[0].tag));
      if (out_ready) begin
        e  = sb.pop_front();
        hs = 1'b1;
      end
    end
    if (sticky_clr) sticky_m = 2'b00;
    if (hs) sticky_m = sticky_m | {e.flq[0], e.flq[1]};
    if (in_valid && in_ready) begin
      n.flq = model(fdiv, fla, flb, fra, frb);
      n.tag = in_tag;
      sb.push_back(n);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fdiv = 1'b0;
    fla = '0; flb = '0; fra = '0; frb = '0; in_tag = '0; sticky_clr = 1'b0;
    sticky_m = 2'b00; held = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_flq", 64'(flq), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_sticky", 64'(sticky_flags), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed special cases
    dir_op("mul0inf", 1'b0, 4'b1000, 4'b0100, 52'h123456789abcd, 52'h0fedcba987654, 4'd1,
           {53'h18000000000000, 5'b00110}, 1'b0);
    chk("mul0inf_sticky", 64'(sticky_flags), 64'h1);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    #1 chk("clr1_sticky", 64'(sticky_flags), 64'h0);

    dir_op("div1by0", 1'b1, 4'b0000, 4'b1000, 52'h0, 52'h0, 4'd2,
           {53'h18000000000000, 5'b01001}, 1'b0);
    chk("div1by0_sticky", 64'(sticky_flags), 64'h2);

    dir_op("clr_vs_inv", 1'b0, 4'b1000, 4'b0100, 52'h0, 52'h0, 4'd3,
           {53'h18000000000000, 5'b00110}, 1'b1);
    chk("clr_vs_inv_sticky", 64'(sticky_flags), 64'h1);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    #1 chk("clr2_sticky", 64'(sticky_flags), 64'h0);

    dir_op("snan_a", 1'b0, 4'b0010, 4'b0000, 52'h1, 52'h7777, 4'd4,
           {53'h18000000000001, 5'b00110}, 1'b0);
    dir_op("qnan_b", 1'b0, 4'b0000, 4'b0001, 52'h3333, 52'h5, 4'd5,
           {53'h18000000000005, 5'b00100}, 1'b0);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;

    // Back-pressure: tags 1,2,3 offered while the consumer stalls for 5 cycles
    fdiv = 1'b0; fla = 4'b0000; flb = 4'b0000; fra = '0; frb = '0;
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_tag    = (i == 0) ? 4'd1 : ((i == 1) ? 4'd2 : 4'd3);
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'(i < 2));
      if (i >= 2) begin
        chk("bp_ov", 64'(out_valid), 64'd1);
        chk("bp_tag_hold", 64'(out_tag), 64'd1);
        if (i == 2) begin
          chk("bp_flq", 64'(flq), 64'({53'h18000000000000, 5'b00000}));
          held = flq;
        end else begin
          chk("bp_flq_stable", 64'(flq), 64'(held));
        end
      end
      @(negedge clk);
    end
    for (int j = 0; j < 3; j++) begin
      out_ready = 1'b1;
      in_valid  = (j == 0);
      in_tag    = 4'd3;
      #1;
      chk("bp_drain_ov", 64'(out_valid), 64'd1);
      chk("bp_drain_tag", 64'(out_tag), 64'(j + 1));
      if (j == 0) chk("bp_accept3", 64'(in_ready), 64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1 chk("bp_empty", 64'(out_valid), 64'd0);

    // Reset with two operations in flight
    @(negedge clk);
    out_ready = 1'b0;
    fla = 4'b1000; flb = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_tag   = 4'(i + 6);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1 chk("mid_ov_before", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", 64'(out_valid), 64'd0);
    chk("mid_rst_flq", 64'(flq), 64'd0);
    chk("mid_rst_tag", 64'(out_tag), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 chk("mid_no_stale", 64'(out_valid), 64'd0);
    end
    chk("mid_sticky", 64'(sticky_flags), 64'd0);

    // Randomized traffic against the scoreboard, then drain
    sticky_m = 2'b00;
    sb.delete();
    for (int c = 0; c < 400; c++) step(1'b1);
    for (int c = 0; c < 20; c++) begin
      if (sb.size() != 0) step(1'b0);
    end
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
